// File: rtl/qix_snd_host_port_pkg.sv
// Shared definitions for the data-CPU side of the sound-board link:
// register indices, status bit positions and the command-strobe FSM states.
package qix_snd_pkg;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_VOL  = 2'd2;
    localparam logic [1:0] REG_RAW  = 2'd3;

    localparam int ST_BUSY   = 7;
    localparam int ST_RVALID = 6;
    localparam int ST_ROVR   = 5;
    localparam int ST_CDROP  = 4;
    localparam int ST_IRQEN  = 1;
    localparam int ST_EPOL   = 0;

    typedef enum logic [1:0] {
        STB_IDLE    = 2'd0,
        STB_ASSERT  = 2'd1,
        STB_HOLDOFF = 2'd2
    } strobe_state_t;

endpackage

// File: rtl/qix_snd_host_port_if.sv
// Data-CPU bus into the sound host port.
// An access happens on every clk_20m edge where cen & cs are both high; rw
// picks read or write, there is no wait state, and dout is valid in the
// same cycle as the access.
interface qix_snd_cpu_if;
    logic       cen;
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (output cen, cs, rw, addr, din, input dout, irq);
    modport slave  (input cen, cs, rw, addr, din, output dout, irq);
endinterface

// File: rtl/qix_snd_host_port_strobe_gen.sv
// Command-strobe sequencer: drives the strobe low for STROBE_LEN cycles after
// a start, then stays busy for HOLDOFF more cycles before it accepts another.
module qix_snd_strobe_gen
    import qix_snd_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 44,
    parameter int unsigned HOLDOFF    = 22
) (
    input  logic          clk_20m,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          strobe_n,
    output strobe_state_t state
);

    localparam int unsigned MAX_LEN = (STROBE_LEN > HOLDOFF) ? STROBE_LEN : HOLDOFF;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] STB_LOAD = CW'(STROBE_LEN - 1);
    localparam logic [CW-1:0] HLD_LOAD = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    strobe_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_20m) begin
        if (!reset_n) begin
            state_q <= STB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter loads N-1 so each phase lasts exactly N cycles; it parks at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? (cnt_q - CNT_ONE) : '0;
        case (state_q)
            STB_IDLE: begin
                if (start) begin
                    state_d = STB_ASSERT;
                    cnt_d   = STB_LOAD;
                end
            end
            STB_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = STB_HOLDOFF;
                    cnt_d   = HLD_LOAD;
                end
            end
            STB_HOLDOFF: begin
                if (cnt_q == '0) state_d = STB_IDLE;
            end
            default: begin
                state_d = STB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q != STB_IDLE);
    assign strobe_n = (state_q != STB_ASSERT);
    assign state    = state_q;

endmodule

// File: rtl/qix_snd_host_port.sv
// Data-CPU end of the sound-board link: command latch + strobe, reply capture
// with IRQ, and the stereo volume register feeding the attenuator.
module qix_snd_host_port
    import qix_snd_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 44,
    parameter int unsigned HOLDOFF    = 22
) (
    input  logic          clk_20m,
    input  logic          reset_n,
    qix_snd_cpu_if.slave  cpu,
    output logic [7:0]    snd_data_out,
    input  logic [7:0]    snd_data_in,
    output logic          snd_irq_to_snd,
    input  logic          snd_irq_from_snd,
    output logic [7:0]    vol_data,
    output strobe_state_t dbg_strobe_state
);

    logic       sel, wr, rd;
    logic       cmd_wr, stat_wr, vol_wr, reply_rd;
    logic       start, busy;
    logic       from_snd_q, hs_edge;
    logic [7:0] reply_q;
    logic       reply_valid_q, reply_ovr_q, cmd_drop_q;
    logic       irq_en_q, edge_pol_q, irq_q;
    logic [7:0] status;
    logic [7:0] dout_c;

    assign sel      = cpu.cen & cpu.cs;
    assign wr       = sel & ~cpu.rw;
    assign rd       = sel & cpu.rw;
    assign cmd_wr   = wr && (cpu.addr == REG_CMD);
    assign stat_wr  = wr && (cpu.addr == REG_STAT);
    assign vol_wr   = wr && (cpu.addr == REG_VOL);
    assign reply_rd = rd && (cpu.addr == REG_CMD);
    assign start    = cmd_wr & ~busy;

    assign hs_edge = edge_pol_q ? ( snd_irq_from_snd & ~from_snd_q)
                                : (~snd_irq_from_snd &  from_snd_q);

    qix_snd_strobe_gen #(
        .STROBE_LEN (STROBE_LEN),
        .HOLDOFF    (HOLDOFF)
    ) u_strobe (
        .clk_20m  (clk_20m),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .strobe_n (snd_irq_to_snd),
        .state    (dbg_strobe_state)
    );

    // History tracks the line even in reset so release never fakes an edge.
    always_ff @(posedge clk_20m) begin
        from_snd_q <= snd_irq_from_snd;
        if (!reset_n) begin
            snd_data_out  <= 8'h00;
            vol_data      <= 8'h00;
            reply_q       <= 8'h00;
            reply_valid_q <= 1'b0;
            reply_ovr_q   <= 1'b0;
            cmd_drop_q    <= 1'b0;
            irq_en_q      <= 1'b0;
            edge_pol_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            irq_q <= irq_en_q & reply_valid_q;
            if (start) snd_data_out <= cpu.din;
            if (cmd_wr && busy) cmd_drop_q <= 1'b1;
            if (vol_wr) vol_data <= cpu.din;
            if (stat_wr) begin
                irq_en_q   <= cpu.din[ST_IRQEN];
                edge_pol_q <= cpu.din[ST_EPOL];
                if (cpu.din[ST_CDROP]) cmd_drop_q <= 1'b0;
            end
            if (stat_wr && cpu.din[ST_ROVR]) reply_ovr_q <= 1'b0;
            // A reply landing on the same cycle as a reply read is not an overrun.
            if (hs_edge) begin
                reply_q       <= snd_data_in;
                reply_valid_q <= 1'b1;
                if (reply_valid_q && !reply_rd) reply_ovr_q <= 1'b1;
            end else if (reply_rd) begin
                reply_valid_q <= 1'b0;
            end
        end
    end

    assign status = {busy, reply_valid_q, reply_ovr_q, cmd_drop_q,
                     2'b00, irq_en_q, edge_pol_q};

    always_comb begin
        dout_c = 8'hFF;
        if (sel) begin
            case (cpu.addr)
                REG_CMD:  dout_c = reply_q;
                REG_STAT: dout_c = status;
                REG_VOL:  dout_c = vol_data;
                REG_RAW:  dout_c = snd_data_in;
                default:  dout_c = 8'hFF;
            endcase
        end
    end

    assign cpu.dout = dout_c;
    assign cpu.irq  = irq_q;

endmodule

// File: tb/tb_qix_snd_host_port.sv
// Directed bench for qix_snd_host_port: command strobe timing, busy drops,
// reply capture/overrun/IRQ and reset behaviour.
module tb_qix_snd_host_port;
    import qix_snd_pkg::*;

    logic          clk_20m = 1'b0;
    logic          reset_n;
    logic [7:0]    snd_data_out;
    logic [7:0]    snd_data_in;
    logic          snd_irq_to_snd;
    logic          snd_irq_from_snd;
    logic [7:0]    vol_data;
    strobe_state_t dbg_strobe_state;

    qix_snd_cpu_if cpu ();

    always #25 clk_20m = ~clk_20m;

    qix_snd_host_port #(.STROBE_LEN(44), .HOLDOFF(22)) dut (
        .clk_20m          (clk_20m),
        .reset_n          (reset_n),
        .cpu              (cpu),
        .snd_data_out     (snd_data_out),
        .snd_data_in      (snd_data_in),
        .snd_irq_to_snd   (snd_irq_to_snd),
        .snd_irq_from_snd (snd_irq_from_snd),
        .vol_data         (vol_data),
        .dbg_strobe_state (dbg_strobe_state)
    );

    logic [7:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] rd_data;
    logic       rd_strobe;
    logic [7:0] busy_cnt, low_cnt;

    task automatic bus_idle();
        cpu.cen  = 1'b0;
        cpu.cs   = 1'b0;
        cpu.rw   = 1'b1;
        cpu.addr = 2'd0;
        cpu.din  = 8'h00;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk_20m);
        cpu.cen = 1'b1; cpu.cs = 1'b1; cpu.rw = 1'b0; cpu.addr = a; cpu.din = d;
        @(posedge clk_20m);
        #1 bus_idle();
    endtask

    task automatic cpu_read(input logic [1:0] a);
        @(negedge clk_20m);
        cpu.cen = 1'b1; cpu.cs = 1'b1; cpu.rw = 1'b1; cpu.addr = a;
        #1;
        rd_data   = cpu.dout;
        rd_strobe = snd_irq_to_snd;
        @(posedge clk_20m);
        #1 bus_idle();
    endtask

    task automatic snd_reply(input logic [7:0] d);
        @(negedge clk_20m);
        snd_data_in = d; snd_irq_from_snd = 1'b1;
        repeat (2) @(negedge clk_20m);
        snd_irq_from_snd = 1'b0;
        repeat (2) @(negedge clk_20m);
    endtask

    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %02h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %02h expected %02h", tag, obs, e);
            end
        end
    endtask

    initial begin
        bus_idle();
        reset_n = 1'b0;
        snd_data_in = 8'h3C;
        snd_irq_from_snd = 1'b0;
        repeat (4) @(posedge clk_20m);
        #1 reset_n = 1'b1;

        // Reset state
        expect_val(8'h01); check("rst_strobe", {7'b0, snd_irq_to_snd});
        expect_val(8'h00); check("rst_irq", {7'b0, cpu.irq});
        expect_val(8'h00); check("rst_cmd_out", snd_data_out);
        expect_val(8'h00); cpu_read(REG_STAT); check("rst_status", rd_data);
        expect_val(8'h00); cpu_read(REG_VOL);  check("rst_vol", rd_data);
        expect_val(8'h00); cpu_read(REG_CMD);  check("rst_reply", rd_data);
        expect_val(8'h3C); cpu_read(REG_RAW);  check("raw_in", rd_data);

        // Unselected access returns FF
        expect_val(8'hFF);
        @(negedge clk_20m);
        cpu.cen = 1'b1; cpu.cs = 1'b0; cpu.rw = 1'b1; cpu.addr = REG_STAT;
        #1 check("unsel_dout", cpu.dout);
        @(posedge clk_20m); #1 bus_idle();

        // Volume register
        cpu_write(REG_VOL, 8'hA5);
        expect_val(8'hA5); check("vol_port", vol_data);
        expect_val(8'hA5); cpu_read(REG_VOL); check("vol_read", rd_data);

        // Single command: strobe length and busy window
        cpu_write(REG_CMD, 8'h5A);
        expect_val(8'h5A); check("cmd_out", snd_data_out);
        busy_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cpu_read(REG_STAT);
            if (!rd_strobe) low_cnt++;
            if (!rd_data[ST_BUSY]) break;
            busy_cnt++;
        end
        expect_val(8'd44); check("strobe_low_cycles", low_cnt);
        expect_val(8'd66); check("busy_cycles", busy_cnt);
        expect_val(8'h00); check("status_after_cmd", rd_data);
        expect_val(8'h01); check("strobe_idle", {7'b0, snd_irq_to_snd});

        // Second command while busy is dropped
        cpu_write(REG_CMD, 8'h11);
        repeat (9) @(posedge clk_20m);
        cpu_write(REG_CMD, 8'h22);
        expect_val(8'h11); check("drop_cmd_out", snd_data_out);
        expect_val(8'h90); cpu_read(REG_STAT); check("drop_status", rd_data);
        cpu_write(REG_STAT, 8'h10);
        expect_val(8'h80); cpu_read(REG_STAT); check("drop_cleared", rd_data);
        for (int i = 0; i < 100; i++) begin
            cpu_read(REG_STAT);
            if (!rd_data[ST_BUSY]) break;
        end
        expect_val(8'h00); check("idle_after_drop", rd_data);

        // Reply capture with IRQ, falling edge
        cpu_write(REG_STAT, 8'h02);
        snd_reply(8'hC3);
        expect_val(8'h01); check("reply_irq", {7'b0, cpu.irq});
        expect_val(8'h42); cpu_read(REG_STAT); check("reply_status", rd_data);
        expect_val(8'hC3); cpu_read(REG_CMD);  check("reply_data", rd_data);
        repeat (2) @(posedge clk_20m);
        #1;
        expect_val(8'h00); check("irq_cleared", {7'b0, cpu.irq});
        expect_val(8'h02); cpu_read(REG_STAT); check("reply_consumed", rd_data);

        // Overrun
        snd_reply(8'h01);
        snd_reply(8'h02);
        expect_val(8'h62); cpu_read(REG_STAT); check("ovr_status", rd_data);
        expect_val(8'h02); cpu_read(REG_CMD);  check("ovr_data", rd_data);
        expect_val(8'h22); cpu_read(REG_STAT); check("ovr_after_read", rd_data);
        cpu_write(REG_STAT, 8'h22);
        expect_val(8'h02); cpu_read(REG_STAT); check("ovr_cleared", rd_data);

        // Edge coincident with a reply read
        snd_reply(8'h05);
        @(negedge clk_20m);
        snd_data_in = 8'h06; snd_irq_from_snd = 1'b1;
        repeat (2) @(negedge clk_20m);
        expect_val(8'h05);
        cpu.cen = 1'b1; cpu.cs = 1'b1; cpu.rw = 1'b1; cpu.addr = REG_CMD;
        snd_irq_from_snd = 1'b0;
        #1 check("coinc_old_data", cpu.dout);
        @(posedge clk_20m); #1 bus_idle();
        expect_val(8'h42); cpu_read(REG_STAT); check("coinc_status", rd_data);
        expect_val(8'h06); cpu_read(REG_CMD);  check("coinc_new_data", rd_data);

        // Reset during the strobe
        cpu_write(REG_CMD, 8'h77);
        repeat (5) @(posedge clk_20m);
        #1;
        expect_val(8'h00); check("strobe_before_rst", {7'b0, snd_irq_to_snd});
        @(negedge clk_20m);
        reset_n = 1'b0;
        @(posedge clk_20m); #1;
        expect_val(8'h01); check("strobe_at_rst", {7'b0, snd_irq_to_snd});
        repeat (2) @(posedge clk_20m);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk_20m);
        #1;
        expect_val(8'h01); check("strobe_after_rst", {7'b0, snd_irq_to_snd});
        expect_val(8'h00); check("irq_after_rst", {7'b0, cpu.irq});
        expect_val(8'h00); check("cmd_out_after_rst", snd_data_out);
        expect_val(8'h00); cpu_read(REG_STAT); check("status_after_rst", rd_data);
        expect_val(8'h00); cpu_read(REG_CMD);  check("reply_after_rst", rd_data);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
